mux_tree_pipe: RTL and testbench
================================

Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 multiplexer tree built from 2:1 mux levels, one register stage per level.
- Successor to the fixed 4-bit 4:1 combinational mux: generalises width and input count, adds a valid/ready handshake, backpressure and bubble collapsing.
- Sits between a producer that presents N candidate words plus a select, and a consumer that can stall.

Parameters:
- WIDTH, 4, bit width of each data word and of y.
- N, 8, number of inputs; power of two, N >= 2.
- LEVELS, $clog2(N), derived and not overridable; number of tree levels, equal to the latency in cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  d and sel are valid this cycle.
- in_ready  output  1  stage 0 can accept; a transfer occurs when in_valid && in_ready.
- d  input  N*WIDTH  flattened inputs; word i = d[i*WIDTH +: WIDTH].
- sel  input  LEVELS  index of the selected word.
- out_valid  output  1  y holds a result.
- out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- y  output  WIDTH  selected word, d[sel] of the matching input transfer.

Behaviour:
- Reset (async assert, sampled release): every stage valid = 0, every data and remaining-select register = 0. Hence out_valid = 0 and y = 0. in_ready = 1 combinationally while rst is low and the pipe is empty.
- Level k (k = 0..LEVELS-1) holds N>>(k+1) words and pairs them as (2j, 2j+1). Word j of the stage-k register = sel[k] ? in[2j+1] : in[2j], so sel[0] (the LSB) is consumed first. Stage k also registers sel[LEVELS-1:k+1] for the later levels.
- The final stage register drives y and out_valid directly; there is no combinational path from d to y.
- Latency: an input transfer at edge t gives out_valid = 1 after edge t+LEVELS-1, i.e. LEVELS register stages. Throughput is one result per cycle while out_ready = 1.
- Stage advance rule, per stage: advance_k = !valid_k || advance_(k+1). Advance of the last stage = !out_valid || out_ready. in_ready = advance_0. Ready is a combinational chain through the stages, so empty stages (bubbles) collapse.
- When a stage advances:
  - it loads the upstream stage's data;
  - valid_k takes the upstream valid (in_valid && in_ready for stage 0);
  - if the upstream stage is empty, valid_k <= 0 and the data register may hold its old value.
- When a stage holds, its data and valid are unchanged.
- Stall: while out_valid && !out_ready, y and out_valid stay stable. Upstream stages keep filling until full, then in_ready = 0.
- Full pipe: holds exactly LEVELS results; the (LEVELS+1)th input is refused until the consumer drains one.
- Simultaneous accept and drain with a full pipe and out_ready = 1: in_ready = 1, and in and out transfer in the same cycle.
- X on an unselected word must not propagate: a 2:1 level outputs the selected operand exactly.
- Reset mid-operation: all in-flight results are discarded immediately (async); out_valid falls without waiting for an edge.
- in_valid = 0 is a don't-care for d and sel.
- out_ready may toggle freely; the block never drops or duplicates a result.

Decomposition:
- Package mux_tree_pkg holds `function automatic int tree_levels(int n)` (returns $clog2(n)) and a compile-time check that N is a power of two.
- Sub-module mux_tree_stage, parameters WIDTH and IN_WORDS:
  - a combinational row of IN_WORDS/2 2:1 muxes plus its valid, data and remaining-select registers;
  - exposes advance and valid.
- Top level generates LEVELS instances of mux_tree_stage and wires the ready chain.

Test Plan (WIDTH=4, N=8, LEVELS=3; d words 0..7 = 'h8,'h9,'ha,'hb,'hc,'hd,'he,'hf):
- Reset then idle -> out_valid = 0, y = 0, in_ready = 1. Asserting rst mid-stream clears out_valid asynchronously.
- Single transfer, sel = 5, out_ready = 1 -> out_valid rises after 3 edges with y = 'hd for exactly one cycle.
- Back-to-back sel = 0..7 on consecutive cycles, out_ready = 1 -> y = 'h8..'hf on 8 consecutive cycles, starting 3 cycles after the first accept.
- out_ready = 0, push 4 items (sel = 1,2,3,4) -> 3 accepted, in_ready = 0 on the 4th, y = 'h9 held stable. Raising out_ready then yields 'h9,'ha,'hb,'hc in order with no loss.
- X on unselected word: word 7 = 'x, sel = 2 -> y = 'ha. With sel = 7 -> y = 'x.
- Random valid/ready toggling for 1000 cycles against a queue scoreboard -> every output equals d[sel] of its input, in order, with no duplicates.

Source files
------------

// File: rtl/mux_tree_pkg.sv
// Shared helpers for the pipelined N:1 mux tree: level count and legality of N.
package mux_tree_pkg;

    function automatic int tree_levels(int n);
        return $clog2(n);
    endfunction

    // N must be a power of two and at least 2 for the pairing scheme to close.
    function automatic bit n_is_legal(int n);
        return (n >= 32'sd2) && ((n & (n - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One level of the mux tree: a row of 2:1 muxes steered by the select LSB,
// followed by the valid, data and remaining-select registers of that level.
module mux_tree_stage
    import mux_tree_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int IN_WORDS = 2,
    parameter int SEL_W    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            up_valid,
    input  logic [IN_WORDS*WIDTH-1:0]       up_data,
    input  logic [SEL_W-1:0]                up_sel,
    input  logic                            down_advance,
    output logic                            advance,
    output logic                            valid,
    output logic [(IN_WORDS/2)*WIDTH-1:0]   data,
    output logic [SEL_W-1:0]                rem_sel
);

    localparam int OUT_WORDS = IN_WORDS / 2;

    logic [OUT_WORDS*WIDTH-1:0] mux_s;
    logic [OUT_WORDS*WIDTH-1:0] data_r;
    logic [SEL_W-1:0]           sel_r;
    logic                       valid_r;

    // A bubble here can always be overwritten, so readiness only chains through full stages.
    assign advance = !valid_r || down_advance;

    // Pairwise 2:1 selection; a known select passes only the chosen operand.
    always_comb begin
        mux_s = '0;
        for (int j = 0; j < OUT_WORDS; j++) begin
            if (up_sel[0]) begin
                mux_s[j*WIDTH +: WIDTH] = up_data[(2*j+1)*WIDTH +: WIDTH];
            end else begin
                mux_s[j*WIDTH +: WIDTH] = up_data[(2*j)*WIDTH +: WIDTH];
            end
        end
    end

    // Stage register: load on advance, keep stale data when the upstream slot is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            sel_r   <= '0;
        end else if (advance) begin
            valid_r <= up_valid;
            if (up_valid) begin
                data_r <= mux_s;
                sel_r  <= up_sel >> 1'b1;
            end
        end
    end

    assign valid   = valid_r;
    assign data    = data_r;
    assign rem_sel = sel_r;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree with valid/ready flow control; one register stage per
// tree level, bubbles collapse through a combinational ready chain.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int N      = 8,
    localparam int LEVELS = tree_levels(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   d,
    input  logic [LEVELS-1:0]    sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     y
);

    if (!n_is_legal(N)) begin : g_bad_n
        $error("mux_tree_pipe: N must be a power of two and at least 2");
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int IN_WORDS = N >> k;

        logic [IN_WORDS*WIDTH-1:0]       up_data_s;
        logic [LEVELS-1:0]               up_sel_s;
        logic                            up_valid_s;
        logic                            down_advance_s;
        logic                            advance_s;
        logic                            valid_s;
        logic [(IN_WORDS/2)*WIDTH-1:0]   data_s;
        logic [LEVELS-1:0]               rem_sel_s;

        if (k == 0) begin : g_head
            assign up_data_s  = d;
            assign up_sel_s   = sel;
            assign up_valid_s = in_valid;
        end else begin : g_body
            assign up_data_s  = g_level[k-1].data_s;
            assign up_sel_s   = g_level[k-1].rem_sel_s;
            assign up_valid_s = g_level[k-1].valid_s;
        end

        if (k == LEVELS - 1) begin : g_tail
            // The last level has no later consumer of its select bits.
            logic sel_unused_s;
            assign sel_unused_s   = ^rem_sel_s;
            assign down_advance_s = out_ready;
        end else begin : g_link
            assign down_advance_s = g_level[k+1].advance_s;
        end

        mux_tree_stage #(
            .WIDTH    (WIDTH),
            .IN_WORDS (IN_WORDS),
            .SEL_W    (LEVELS)
        ) u_stage (
            .clk          (clk),
            .rst          (rst),
            .up_valid     (up_valid_s),
            .up_data      (up_data_s),
            .up_sel       (up_sel_s),
            .down_advance (down_advance_s),
            .advance      (advance_s),
            .valid        (valid_s),
            .data         (data_s),
            .rem_sel      (rem_sel_s)
        );
    end

    assign in_ready  = g_level[0].advance_s;
    assign out_valid = g_level[LEVELS-1].valid_s;
    assign y         = g_level[LEVELS-1].data_s;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed and randomised bench for mux_tree_pipe (WIDTH=4, N=8, LEVELS=3).
module tb_mux_tree_pipe;

    localparam int WIDTH  = 4;
    localparam int N      = 8;
    localparam int LEVELS = 3;
    localparam logic [N*WIDTH-1:0] D_REF = 32'hfedc_ba98;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*WIDTH-1:0]   d;
    logic [LEVELS-1:0]    sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     y;

    int               n_checks = 0;
    int               n_fail   = 0;
    bit               sb_en    = 1'b0;
    logic [WIDTH-1:0] sb_q[$];

    mux_tree_pipe #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every output transfer must match the oldest outstanding input.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    check_eq("sb_data", 32'(y), 32'(sb_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(d[sel*WIDTH +: WIDTH]);
            end
        end
    end

    initial begin
        logic [LEVELS-1:0] st_sel [4];
        logic              st_rdy [4];
        st_sel = '{3'd1, 3'd2, 3'd3, 3'd4};
        st_rdy = '{1'b1, 1'b1, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 3'd0;
        d         = D_REF;

        // Reset and idle
        repeat (2) step();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_y", 32'(y), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);
        check_eq("idle_out_valid", 32'(out_valid), 32'd0);
        check_eq("idle_y", 32'(y), 32'd0);

        // Single transfer, sel = 5: visible after the third edge, for one cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = 3'd5;
        step();
        in_valid = 1'b0;
        check_eq("single_e1_valid", 32'(out_valid), 32'd0);
        step();
        check_eq("single_e2_valid", 32'(out_valid), 32'd0);
        step();
        check_eq("single_e3_valid", 32'(out_valid), 32'd1);
        check_eq("single_e3_y", 32'(y), 32'hd);
        step();
        check_eq("single_e4_valid", 32'(out_valid), 32'd0);

        // Back-to-back sel = 0..7 with the consumer always ready
        for (int c = 0; c <= 10; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                sel      = 3'(c);
            end else begin
                in_valid = 1'b0;
            end
            step();
            check_eq($sformatf("b2b_valid_%0d", c), 32'(out_valid), 32'((c >= 2) && (c <= 9)));
            if ((c >= 2) && (c <= 9)) begin
                check_eq($sformatf("b2b_y_%0d", c), 32'(y), 32'(8 + c - 2));
            end
        end

        // Stall: three items fill the pipe, the fourth is refused
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            sel      = st_sel[i];
            #1;
            check_eq($sformatf("stall_in_ready_%0d", i), 32'(in_ready), 32'(st_rdy[i]));
            step();
        end
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_y", 32'(y), 32'h9);
        step();
        check_eq("stall_y_hold", 32'(y), 32'h9);
        check_eq("stall_full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check_eq("full_drain_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("drain_y0", 32'(y), 32'ha);
        check_eq("drain_v0", 32'(out_valid), 32'd1);
        step();
        check_eq("drain_y1", 32'(y), 32'hb);
        step();
        check_eq("drain_y2", 32'(y), 32'hc);
        step();
        check_eq("drain_empty", 32'(out_valid), 32'd0);

        // Unknown on an unselected word must not leak into the result
        d          = D_REF;
        d[31:28]   = 4'bxxxx;
        in_valid   = 1'b1;
        sel        = 3'd2;
        step();
        in_valid = 1'b0;
        step();
        step();
        check_eq("xsel_valid", 32'(out_valid), 32'd1);
        check_eq("xsel_y", 32'(y), 32'ha);
        step();
        d = D_REF;

        // Random valid/ready toggling against the scoreboard
        sb_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            sel       = 3'($urandom_range(0, 7));
            d         = 32'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        check_eq("sb_leftover", 32'(sb_q.size()), 32'd0);
        sb_en = 1'b0;

        // Reset mid-stream drops out_valid without waiting for a clock edge
        d         = D_REF;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 3'd6;
        repeat (3) step();
        in_valid = 1'b0;
        check_eq("mid_valid", 32'(out_valid), 32'd1);
        check_eq("mid_y", 32'(y), 32'he);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", 32'(out_valid), 32'd0);
        check_eq("async_rst_y", 32'(y), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
